timer_reload: RTL and testbench
===============================

Name: timer_reload

Overview:
Parametrised successor to the fixed 32-bit preset/down-count timer: a WIDTH-bit down-counting timer with an optional prescaler, one-shot or periodic (auto-reload) mode, an enable input, a one-cycle expiry pulse and a sticky interrupt flag. It sits beside the sensor-interface FSMs in the WSN SoC and paces sampling intervals and timeouts without software reloading.

Parameters:
WIDTH, 32, counter and preset/reload width in bits (>=2)
PRESCALE_WIDTH, 8, prescaler divisor width in bits (>=1)

Ports:
Clk_i  in  1  clock, all state updates on the rising edge
Reset_i  in  1  synchronous, active-high reset
Enable_i  in  1  1 = prescaler and counter advance; 0 = freeze all counting state
Preset_i  in  1  load PresetVal_i, Prescale_i and Periodic_i and start the timer
PresetVal_i  in  WIDTH  start value, also the reload value
Prescale_i  in  PRESCALE_WIDTH  divisor-1; 0 = one tick per enabled cycle
Periodic_i  in  1  mode captured on Preset: 1 = auto-reload, 0 = one-shot
IrqClr_i  in  1  clear the sticky Irq_o
Value_o  out  WIDTH  current counter value
Zero_o  out  1  combinational, Value_o == 0
Running_o  out  1  state == RUN
Expired_o  out  1  registered one-cycle expiry pulse
Irq_o  out  1  sticky expiry flag

Behaviour:
- Reset (Reset_i=1 at an edge) has the highest priority. Value=0, reload=0, prescaler=0, mode=one-shot, state=IDLE, Expired_o=0, Irq_o=0. Zero_o is therefore 1 and Running_o is 0. Reset mid-count aborts with no expiry.
- States are IDLE, RUN and DONE (one-shot finished).
- Preset_i (priority over Enable_i and tick, in any state):
  - Value <= PresetVal_i, reload <= PresetVal_i, prescaler <= Prescale_i, mode <= Periodic_i.
  - Next state is RUN if PresetVal_i != 0, else IDLE with no expiry and no Irq.
  - A Preset coinciding with an expiry suppresses that expiry: no Expired_o pulse and no Irq set.
- Tick is generated only in RUN with Enable_i=1 and the prescaler at 0.
  - On a tick the prescaler reloads to the latched divisor.
  - Otherwise, in RUN with Enable_i=1, the prescaler decrements.
  - The tick period is latched Prescale_i + 1 enabled cycles.
- On a tick with Value > 1: Value <= Value - 1.
- On a tick with Value == 1 (expiry event):
  - One-shot: Value <= 0, state RUN -> DONE.
  - Periodic: Value <= reload and state stays RUN. Reload = 1 therefore expires on every tick.
  - Either mode: Expired_o = 1 in the following cycle only, and Irq_o <= 1.
- Timing: a one-shot preset with N expires after exactly N * (P+1) enabled cycles from the Preset edge. Periodic period = N * (P+1) enabled cycles.
- Enable_i=0 freezes prescaler, Value and state. Expired_o still returns to 0 after its single cycle.
- DONE and IDLE hold Value and ignore Enable_i until the next Preset_i.
- Irq_o stays set until an IrqClr_i edge. If set and clear happen in the same cycle, set wins.
- Arithmetic is unsigned modulo 2^WIDTH. Value never underflows because the 1 -> 0 or reload path is checked before decrementing.

Decomposition:
- Package timer_reload_pkg holds the state enum (IDLE, RUN, DONE) and the mode constants (MODE_ONESHOT = 0, MODE_PERIODIC = 1).
- Sub-module timer_prescaler (PRESCALE_WIDTH):
  - Inputs: clock, reset, load, divisor, run-enable.
  - Output: tick.
  - Reused by other pacing blocks.
- The top level holds the FSM, counter, reload register and Irq logic.

Test Plan:
- Reset mid-run: Preset 100, P=0, run 10 cycles, Reset_i=1 -> Value_o=0, Zero_o=1, Running_o=0, Irq_o=0, and no Expired_o pulse follows.
- One-shot: Preset 5, P=0, Periodic=0, Enable=1 -> Value 4,3,2,1,0; Expired_o high exactly 1 cycle when Value_o first reads 0 (5 cycles after Preset); state DONE; Value holds 0 for 20 further cycles.
- Prescaled periodic: Preset 3, P=2, Periodic=1 -> Expired_o pulses every 9 cycles, Value_o cycles 3,2,1,3..., each value held 3 cycles; Irq_o set after the first pulse and held.
- Enable gating: Preset 4, P=0, drop Enable for 7 cycles after Value=2 -> Value stays 2 during the gap, expiry arrives 7 cycles later than ungated.
- Collisions: Preset 8 issued on the cycle Value==1 ticks -> Value_o=8, no Expired_o, Irq unchanged. Also IrqClr_i asserted on the expiry-set cycle -> Irq_o=1.
- Zero and reload-1 edge cases: Preset 0 -> IDLE, Zero_o=1, no pulse. Preset 1, periodic, P=0 -> Expired_o asserted every cycle, Value_o constant 1.

Source files
------------

// File: rtl/timer_reload_pkg.sv
// Shared types for the reloadable down-count timer: FSM states and mode encodings.
package timer_reload_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_reload_if.sv
// Control/status bundle of the timer; the slave side is the timer itself.
interface timer_reload_if #(
  parameter int WIDTH          = 32,
  parameter int PRESCALE_WIDTH = 8
);
  logic                      Enable_i;
  logic                      Preset_i;
  logic [WIDTH-1:0]          PresetVal_i;
  logic [PRESCALE_WIDTH-1:0] Prescale_i;
  logic                      Periodic_i;
  logic                      IrqClr_i;
  logic [WIDTH-1:0]          Value_o;
  logic                      Zero_o;
  logic                      Running_o;
  logic                      Expired_o;
  logic                      Irq_o;

  modport slave (
    input  Enable_i, Preset_i, PresetVal_i, Prescale_i, Periodic_i, IrqClr_i,
    output Value_o, Zero_o, Running_o, Expired_o, Irq_o
  );

  modport master (
    output Enable_i, Preset_i, PresetVal_i, Prescale_i, Periodic_i, IrqClr_i,
    input  Value_o, Zero_o, Running_o, Expired_o, Irq_o
  );
endinterface

// File: rtl/timer_prescaler.sv
// Programmable tick divider: one tick every divisor+1 cycles in which run_i is high.
module timer_prescaler #(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      load_i,
  input  logic [PRESCALE_WIDTH-1:0] divisor_i,
  input  logic                      run_i,
  output logic                      tick_o
);

  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] div_q, div_d;

  assign tick_o = run_i && (cnt_q == '0);

  // Next-state: load wins, then reload on tick, else count down while running.
  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    if (load_i) begin
      cnt_d = divisor_i;
      div_d = divisor_i;
    end else if (tick_o) begin
      cnt_d = div_q;
    end else if (run_i) begin
      cnt_d = cnt_q - PRESCALE_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/timer_reload.sv
// WIDTH-bit down-counting timer with prescaler, one-shot/periodic reload,
// registered expiry pulse and sticky interrupt flag.
module timer_reload
  import timer_reload_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic           Clk_i,
  input  logic           Reset_i,
  timer_reload_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             expired_q, expired_d;
  logic             irq_q, irq_d;
  logic             run_s;
  logic             tick_s;

  assign run_s = (state_q == RUN) && bus.Enable_i;

  timer_prescaler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clk_i     (Clk_i),
    .rst_i     (Reset_i),
    .load_i    (bus.Preset_i),
    .divisor_i (bus.Prescale_i),
    .run_i     (run_s),
    .tick_o    (tick_s)
  );

  // Next-state: Preset overrides ticks, so an expiry on the same edge is dropped.
  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    reload_d  = reload_q;
    mode_d    = mode_q;
    expired_d = 1'b0;
    irq_d     = irq_q & ~bus.IrqClr_i;
    if (bus.Preset_i) begin
      value_d  = bus.PresetVal_i;
      reload_d = bus.PresetVal_i;
      mode_d   = bus.Periodic_i;
      state_d  = (bus.PresetVal_i != '0) ? RUN : IDLE;
    end else if (tick_s) begin
      if (value_q == ONE) begin
        expired_d = 1'b1;
        irq_d     = 1'b1;
        if (mode_q == MODE_PERIODIC) begin
          value_d = reload_q;
        end else begin
          value_d = '0;
          state_d = DONE;
        end
      end else begin
        value_d = value_q - ONE;
      end
    end else begin
      value_d = value_q;
    end
  end

  // Timer state registers.
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_q   <= IDLE;
      value_q   <= '0;
      reload_q  <= '0;
      mode_q    <= MODE_ONESHOT;
      expired_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      reload_q  <= reload_d;
      mode_q    <= mode_d;
      expired_q <= expired_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.Value_o   = value_q;
  assign bus.Zero_o    = (value_q == '0);
  assign bus.Running_o = (state_q == RUN);
  assign bus.Expired_o = expired_q;
  assign bus.Irq_o     = irq_q;

endmodule

// File: tb/tb_timer_reload.sv
// Scoreboard bench for timer_reload: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_timer_reload;

  localparam int WIDTH = 32;
  localparam int PW    = 8;

  localparam int S_VAL = 0;
  localparam int S_ZERO = 1;
  localparam int S_RUN = 2;
  localparam int S_EXP = 3;
  localparam int S_IRQ = 4;

  typedef struct {
    int          cyc;
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sbq[$];
  exp_t mon_e;
  logic [31:0] mon_act;

  timer_reload_if #(.WIDTH(WIDTH), .PRESCALE_WIDTH(PW)) tif ();

  timer_reload #(.WIDTH(WIDTH), .PRESCALE_WIDTH(PW)) dut (
    .Clk_i   (clk),
    .Reset_i (rst),
    .bus     (tif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_at(input int c, input string n, input int s, input logic [31:0] e);
    exp_t x;
    x.cyc = c;
    x.name = n;
    x.sel = s;
    x.exp = e;
    sbq.push_back(x);
  endfunction

  function automatic logic [31:0] sample(input int s);
    case (s)
      S_VAL:   return tif.Value_o;
      S_ZERO:  return {31'd0, tif.Zero_o};
      S_RUN:   return {31'd0, tif.Running_o};
      S_EXP:   return {31'd0, tif.Expired_o};
      S_IRQ:   return {31'd0, tif.Irq_o};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e = sbq.pop_front();
      n_checks++;
      if (mon_e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s cyc=%0d: check missed at cyc %0d", mon_e.name, mon_e.cyc, cyc);
      end else begin
        mon_act = sample(mon_e.sel);
        if (mon_act !== mon_e.exp) begin
          n_fail++;
          $display("FAIL %s cyc=%0d: got %0d expected %0d", mon_e.name, mon_e.cyc, mon_act, mon_e.exp);
        end
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_preset(input logic [31:0] v, input logic [7:0] p, input logic per, output int b);
    tif.Preset_i    = 1'b1;
    tif.PresetVal_i = v;
    tif.Prescale_i  = p;
    tif.Periodic_i  = per;
    b = cyc + 1;
  endtask

  initial begin
    int b;
    int b2;
    rst             = 1'b1;
    tif.Enable_i    = 1'b0;
    tif.Preset_i    = 1'b0;
    tif.PresetVal_i = 32'd0;
    tif.Prescale_i  = 8'd0;
    tif.Periodic_i  = 1'b0;
    tif.IrqClr_i    = 1'b0;
    repeat (3) @(negedge clk);
    expect_at(cyc + 1, "rst_value", S_VAL, 32'd0);
    expect_at(cyc + 1, "rst_zero", S_ZERO, 32'd1);
    expect_at(cyc + 1, "rst_running", S_RUN, 32'd0);
    expect_at(cyc + 1, "rst_expired", S_EXP, 32'd0);
    expect_at(cyc + 1, "rst_irq", S_IRQ, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tif.Enable_i = 1'b1;

    // Reset in the middle of a count
    do_preset(32'd100, 8'd0, 1'b0, b);
    expect_at(b, "s1_load", S_VAL, 32'd100);
    expect_at(b + 5, "s1_running", S_RUN, 32'd1);
    expect_at(b + 9, "s1_value", S_VAL, 32'd91);
    wait_until(b);
    tif.Preset_i = 1'b0;
    wait_until(b + 9);
    rst = 1'b1;
    expect_at(b + 10, "s1_rst_value", S_VAL, 32'd0);
    expect_at(b + 10, "s1_rst_zero", S_ZERO, 32'd1);
    expect_at(b + 10, "s1_rst_running", S_RUN, 32'd0);
    expect_at(b + 10, "s1_rst_irq", S_IRQ, 32'd0);
    for (int k = 0; k < 6; k++) expect_at(b + 10 + k, "s1_no_expiry", S_EXP, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_until(b + 16);

    // One-shot 5, no prescale
    do_preset(32'd5, 8'd0, 1'b0, b);
    for (int k = 0; k < 7; k++) begin
      expect_at(b + k, "s2_value", S_VAL, (k <= 5) ? 32'(5 - k) : 32'd0);
      expect_at(b + k, "s2_expired", S_EXP, (k == 5) ? 32'd1 : 32'd0);
      expect_at(b + k, "s2_running", S_RUN, (k < 5) ? 32'd1 : 32'd0);
      expect_at(b + k, "s2_zero", S_ZERO, (k >= 5) ? 32'd1 : 32'd0);
      expect_at(b + k, "s2_irq", S_IRQ, (k >= 5) ? 32'd1 : 32'd0);
    end
    expect_at(b + 25, "s2_hold_value", S_VAL, 32'd0);
    expect_at(b + 25, "s2_hold_running", S_RUN, 32'd0);
    expect_at(b + 25, "s2_hold_expired", S_EXP, 32'd0);
    wait_until(b);
    tif.Preset_i = 1'b0;
    wait_until(b + 25);
    tif.IrqClr_i = 1'b1;
    expect_at(cyc + 1, "s2_irq_clear", S_IRQ, 32'd0);
    @(negedge clk);
    tif.IrqClr_i = 1'b0;

    // Periodic 3 with divisor 3
    do_preset(32'd3, 8'd2, 1'b1, b);
    for (int k = 0; k < 28; k++) begin
      expect_at(b + k, "s3_value", S_VAL, 32'(3 - ((k / 3) % 3)));
      expect_at(b + k, "s3_expired", S_EXP, (k > 0 && (k % 9) == 0) ? 32'd1 : 32'd0);
      expect_at(b + k, "s3_irq", S_IRQ, (k >= 9) ? 32'd1 : 32'd0);
    end
    wait_until(b);
    tif.Preset_i = 1'b0;
    wait_until(b + 27);
    tif.IrqClr_i = 1'b1;
    @(negedge clk);
    tif.IrqClr_i = 1'b0;

    // Enable gap of 7 cycles while Value is 2
    do_preset(32'd4, 8'd0, 1'b0, b);
    expect_at(b, "s4_value", S_VAL, 32'd4);
    expect_at(b + 1, "s4_value", S_VAL, 32'd3);
    for (int k = 2; k < 10; k++) begin
      expect_at(b + k, "s4_frozen", S_VAL, 32'd2);
      expect_at(b + k, "s4_running", S_RUN, 32'd1);
    end
    expect_at(b + 10, "s4_value", S_VAL, 32'd1);
    expect_at(b + 10, "s4_expired_early", S_EXP, 32'd0);
    expect_at(b + 11, "s4_value", S_VAL, 32'd0);
    expect_at(b + 11, "s4_expired", S_EXP, 32'd1);
    expect_at(b + 11, "s4_irq", S_IRQ, 32'd1);
    expect_at(b + 12, "s4_expired_end", S_EXP, 32'd0);
    wait_until(b);
    tif.Preset_i = 1'b0;
    wait_until(b + 2);
    tif.Enable_i = 1'b0;
    wait_until(b + 9);
    tif.Enable_i = 1'b1;
    wait_until(b + 12);
    tif.IrqClr_i = 1'b1;
    expect_at(cyc + 1, "s4_irq_clear", S_IRQ, 32'd0);
    @(negedge clk);
    tif.IrqClr_i = 1'b0;

    // Preset on the expiring tick, then IrqClr on the expiry edge
    do_preset(32'd3, 8'd0, 1'b0, b);
    expect_at(b + 2, "s5_value_one", S_VAL, 32'd1);
    wait_until(b);
    tif.Preset_i = 1'b0;
    wait_until(b + 2);
    do_preset(32'd8, 8'd0, 1'b0, b2);
    expect_at(b2, "s5_coll_value", S_VAL, 32'd8);
    expect_at(b2, "s5_coll_expired", S_EXP, 32'd0);
    expect_at(b2, "s5_coll_irq", S_IRQ, 32'd0);
    expect_at(b2, "s5_coll_running", S_RUN, 32'd1);
    expect_at(b2 + 7, "s5_value_one", S_VAL, 32'd1);
    expect_at(b2 + 7, "s5_irq_pre", S_IRQ, 32'd0);
    expect_at(b2 + 8, "s5_value_zero", S_VAL, 32'd0);
    expect_at(b2 + 8, "s5_expired", S_EXP, 32'd1);
    expect_at(b2 + 8, "s5_set_beats_clr", S_IRQ, 32'd1);
    expect_at(b2 + 9, "s5_irq_hold", S_IRQ, 32'd1);
    expect_at(b2 + 9, "s5_expired_end", S_EXP, 32'd0);
    wait_until(b2);
    tif.Preset_i = 1'b0;
    wait_until(b2 + 7);
    tif.IrqClr_i = 1'b1;
    wait_until(b2 + 8);
    tif.IrqClr_i = 1'b0;
    wait_until(b2 + 9);

    // Preset 0 goes IDLE without expiry
    tif.IrqClr_i = 1'b1;
    do_preset(32'd0, 8'd0, 1'b0, b);
    for (int k = 0; k < 4; k++) begin
      expect_at(b + k, "s6_zero_value", S_VAL, 32'd0);
      expect_at(b + k, "s6_zero_flag", S_ZERO, 32'd1);
      expect_at(b + k, "s6_zero_running", S_RUN, 32'd0);
      expect_at(b + k, "s6_zero_expired", S_EXP, 32'd0);
      expect_at(b + k, "s6_zero_irq", S_IRQ, 32'd0);
    end
    wait_until(b);
    tif.Preset_i = 1'b0;
    tif.IrqClr_i = 1'b0;
    wait_until(b + 3);

    // Periodic reload 1 expires every tick; a Preset on that tick suppresses it
    do_preset(32'd1, 8'd0, 1'b1, b);
    for (int k = 0; k < 6; k++) begin
      expect_at(b + k, "s6_one_value", S_VAL, 32'd1);
      expect_at(b + k, "s6_one_zero", S_ZERO, 32'd0);
      expect_at(b + k, "s6_one_expired", S_EXP, (k >= 1) ? 32'd1 : 32'd0);
      expect_at(b + k, "s6_one_irq", S_IRQ, (k >= 1) ? 32'd1 : 32'd0);
    end
    wait_until(b);
    tif.Preset_i = 1'b0;
    wait_until(b + 5);
    do_preset(32'd0, 8'd0, 1'b0, b2);
    expect_at(b2, "s6_stop_expired", S_EXP, 32'd0);
    expect_at(b2, "s6_stop_value", S_VAL, 32'd0);
    expect_at(b2, "s6_stop_running", S_RUN, 32'd0);
    expect_at(b2, "s6_stop_irq", S_IRQ, 32'd1);
    wait_until(b2);
    tif.Preset_i = 1'b0;

    for (int i = 0; i < 100 && sbq.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
